// File: rtl/if_icache_if.sv
// if_icache_if: fetch-side and memory-side signals of the instruction cache
interface if_icache_if #(parameter int ADDR_W = 32);
  logic              cpu_ce;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_inst;
  logic              stallreq_from_if_cache;
  logic              invalidate;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  modport master (
    output cpu_ce, cpu_addr, invalidate, mem_ack, mem_rdata,
    input  cpu_inst, stallreq_from_if_cache, mem_req, mem_addr
  );
  modport slave (
    input  cpu_ce, cpu_addr, invalidate, mem_ack, mem_rdata,
    output cpu_inst, stallreq_from_if_cache, mem_req, mem_addr
  );
endinterface

// File: rtl/if_icache.sv
// if_icache: direct-mapped read-only instruction cache with word-serial line refill
module if_icache #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2,
  parameter int ADDR_W     = 32
) (
  input logic        clk,
  input logic        rst,
  if_icache_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - WORD_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;
  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [WORD_BITS-1:0]  cnt_q, cnt_d;
  logic                  inv_q, inv_d;
  logic [TAG_W-1:0]      tag_arr [LINES];
  logic [31:0]           data_arr [LINES][WORDS];
  logic [WORD_BITS-1:0]  word;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit, ack, last, unused_bits;
  assign word        = bus.cpu_addr[WORD_BITS+1:2];
  assign idx         = bus.cpu_addr[WORD_BITS+2 +: INDEX_BITS];
  assign tag         = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^bus.cpu_addr[1:0];
  assign hit         = bus.cpu_ce & valid_q[idx] & (tag_arr[idx] == tag);
  assign ack         = bus.mem_ack & (state_q == REFILL);
  assign last        = ack & (&cnt_q);
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    case (state_q)
      IDLE: begin
        valid_d = bus.invalidate ? '0 : valid_q;
        if (bus.cpu_ce & ~hit) begin
          state_d    = REFILL;
          miss_tag_d = tag;
          miss_idx_d = idx;
          cnt_d      = '0;
          inv_d      = 1'b0;
        end
      end
      REFILL: begin
        inv_d = inv_q | bus.invalidate;
        cnt_d = ack ? cnt_q + 1'b1 : cnt_q;
        if (last) begin
          // a pending invalidate overrides the line just filled
          state_d = FILL_DONE;
          valid_d = (inv_q | bus.invalidate) ? '0 : valid_q | (LINES'(1) << miss_idx_q);
          inv_d   = 1'b0;
        end
      end
      FILL_DONE: begin
        state_d = IDLE;
        valid_d = bus.invalidate ? '0 : valid_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ack) data_arr[miss_idx_q][cnt_q] <= bus.mem_rdata;
    if (last) tag_arr[miss_idx_q] <= miss_tag_q;
  end
  assign bus.cpu_inst               = (rst && state_q == IDLE && hit) ? data_arr[idx][word] : '0;
  assign bus.stallreq_from_if_cache = rst && (state_q != IDLE || (bus.cpu_ce && !hit));
  assign bus.mem_req                = rst && state_q == REFILL;
  assign bus.mem_addr               = bus.mem_req ? {miss_tag_q, miss_idx_q, cnt_q, 2'b00} : '0;
endmodule

// File: tb/tb_if_icache.sv
// tb_if_icache: directed scenarios for the instruction cache
module tb_if_icache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passes = 0;
  int sc, wd, ba, us;
  if_icache_if #(.ADDR_W(32)) bus ();
  if_icache dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // memory responder: acks each word after `delay` wait cycles, returns dbase+k
  task automatic run_fill(input logic [31:0] base, input int delay, input logic [31:0] dbase,
                          input int inv_cycle, output int stall_cyc, output int words,
                          output int bad_addr, output int unstable);
    int wait_cnt = 0;
    logic [31:0] prev = '0;
    stall_cyc = 0; words = 0; bad_addr = 0; unstable = 0;
    while (bus.stallreq_from_if_cache && stall_cyc < 200) begin
      bus.invalidate = (stall_cyc == inv_cycle);
      if (bus.mem_req) begin
        if (bus.mem_addr !== base + 32'((words % 4) * 4)) bad_addr++;
        if (wait_cnt > 0 && bus.mem_addr !== prev) unstable++;
        prev = bus.mem_addr;
        if (wait_cnt == delay) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = dbase + 32'(words % 4); words++; wait_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0; wait_cnt++;
        end
      end else begin
        if (wait_cnt != 0) unstable++;
        bus.mem_ack = 1'b0;
      end
      stall_cyc++;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0; bus.invalidate = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    end
  endtask
  task automatic test_reset;
    rst = 1'b0; bus.cpu_ce = 1'b1; bus.cpu_addr = 32'h40;
    bus.invalidate = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stallreq_from_if_cache); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else passes++;
    checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_addr); else passes++;
    checks++; if (bus.cpu_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", bus.cpu_inst); else passes++;
    @(negedge clk); rst = 1'b1; #1;
  endtask
  task automatic test_cold_miss;
    bus.cpu_ce = 1'b1; bus.cpu_addr = 32'h40; #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b1) $display("FAIL cold_stall: got %b want 1", bus.stallreq_from_if_cache); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL cold_req_same_cycle: got %b want 0", bus.mem_req); else passes++;
    run_fill(32'h40, 1, 32'h1111_0000, -1, sc, wd, ba, us);
    checks++; if (sc !== 10) $display("FAIL cold_stall_cycles: got %0d want 10", sc); else passes++;
    checks++; if (ba !== 0 || wd !== 4) $display("FAIL cold_addr_seq: bad %0d words %0d want 0 and 4", ba, wd); else passes++;
    checks++; if (bus.cpu_inst !== 32'h1111_0000) $display("FAIL cold_inst: got %h want 11110000", bus.cpu_inst); else passes++;
    checks++; if (bus.stallreq_from_if_cache !== 1'b0) $display("FAIL cold_stall_drop: got %b want 0", bus.stallreq_from_if_cache); else passes++;
  endtask
  task automatic test_line_hit;
    bus.cpu_addr = 32'h4C; #1;
    checks++; if (bus.cpu_inst !== 32'h1111_0003) $display("FAIL hit_4c: got %h want 11110003", bus.cpu_inst); else passes++;
    checks++; if (bus.stallreq_from_if_cache !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL hit_4c_ctl: stall %b req %b want 0 0", bus.stallreq_from_if_cache, bus.mem_req); else passes++;
    bus.cpu_addr = 32'h46; #1;
    checks++; if (bus.cpu_inst !== 32'h1111_0001) $display("FAIL hit_44: got %h want 11110001", bus.cpu_inst); else passes++;
    bus.cpu_ce = 1'b0; #1;
    checks++; if (bus.cpu_inst !== 32'h0 || bus.stallreq_from_if_cache !== 1'b0) $display("FAIL no_fetch: inst %h stall %b want 0 0", bus.cpu_inst, bus.stallreq_from_if_cache); else passes++;
    @(posedge clk); #1;
    bus.cpu_ce = 1'b1; bus.cpu_addr = 32'h48; #1;
    checks++; if (bus.cpu_inst !== 32'h1111_0002) $display("FAIL hit_after_idle: got %h want 11110002", bus.cpu_inst); else passes++;
  endtask
  task automatic test_conflict;
    bus.cpu_addr = 32'h440; #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b1) $display("FAIL conflict_miss: got %b want 1", bus.stallreq_from_if_cache); else passes++;
    run_fill(32'h440, 0, 32'h2222_0000, -1, sc, wd, ba, us);
    checks++; if (sc !== 6 || ba !== 0) $display("FAIL conflict_fill: cycles %0d bad %0d want 6 0", sc, ba); else passes++;
    checks++; if (bus.cpu_inst !== 32'h2222_0000) $display("FAIL conflict_inst: got %h want 22220000", bus.cpu_inst); else passes++;
    bus.cpu_addr = 32'h40; #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b1) $display("FAIL evicted_miss: got %b want 1", bus.stallreq_from_if_cache); else passes++;
    run_fill(32'h40, 1, 32'h1111_0000, -1, sc, wd, ba, us);
    checks++; if (bus.cpu_inst !== 32'h1111_0000 || ba !== 0) $display("FAIL evicted_refill: inst %h bad %0d want 11110000 0", bus.cpu_inst, ba); else passes++;
  endtask
  task automatic test_slow_mem;
    bus.cpu_addr = 32'h1080; #1;
    run_fill(32'h1080, 3, 32'h3333_0000, -1, sc, wd, ba, us);
    checks++; if (sc !== 18) $display("FAIL slow_stall_cycles: got %0d want 18", sc); else passes++;
    checks++; if (us !== 0 || ba !== 0) $display("FAIL slow_stable: unstable %0d bad %0d want 0 0", us, ba); else passes++;
    checks++; if (bus.cpu_inst !== 32'h3333_0000) $display("FAIL slow_inst: got %h want 33330000", bus.cpu_inst); else passes++;
    bus.cpu_addr = 32'h108C; #1;
    checks++; if (bus.cpu_inst !== 32'h3333_0003) $display("FAIL slow_inst3: got %h want 33330003", bus.cpu_inst); else passes++;
  endtask
  task automatic test_invalidate_refill;
    bus.cpu_addr = 32'h2000; #1;
    run_fill(32'h2000, 1, 32'h4444_0000, 2, sc, wd, ba, us);
    checks++; if (wd !== 8 || sc !== 20) $display("FAIL inv_refetch: words %0d cycles %0d want 8 20", wd, sc); else passes++;
    checks++; if (bus.cpu_inst !== 32'h4444_0000 || ba !== 0) $display("FAIL inv_final: inst %h bad %0d want 44440000 0", bus.cpu_inst, ba); else passes++;
    bus.cpu_addr = 32'h1080; #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b1) $display("FAIL inv_other_line: got %b want 1", bus.stallreq_from_if_cache); else passes++;
    bus.cpu_ce = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_invalidate_idle;
    bus.cpu_ce = 1'b1; bus.cpu_addr = 32'h2004; bus.invalidate = 1'b1; #1;
    checks++; if (bus.cpu_inst !== 32'h4444_0001 || bus.stallreq_from_if_cache !== 1'b0) $display("FAIL inv_idle_same: inst %h stall %b want 44440001 0", bus.cpu_inst, bus.stallreq_from_if_cache); else passes++;
    @(posedge clk); #1;
    bus.invalidate = 1'b0; #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b1) $display("FAIL inv_idle_next: got %b want 1", bus.stallreq_from_if_cache); else passes++;
    bus.cpu_ce = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_refill;
    bus.cpu_ce = 1'b1; bus.cpu_addr = 32'h40; #1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_0000;
    @(posedge clk); #1;
    bus.mem_rdata = 32'h5555_0001;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checks++; if (bus.mem_addr !== 32'h48 || bus.mem_req !== 1'b1) $display("FAIL mid_refill_addr: addr %h req %b want 48 1", bus.mem_addr, bus.mem_req); else passes++;
    #2 rst = 1'b0; #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.stallreq_from_if_cache !== 1'b0) $display("FAIL async_reset: req %b stall %b want 0 0", bus.mem_req, bus.stallreq_from_if_cache); else passes++;
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (bus.stallreq_from_if_cache !== 1'b1) $display("FAIL post_reset_miss: got %b want 1", bus.stallreq_from_if_cache); else passes++;
    run_fill(32'h40, 1, 32'h1111_0000, -1, sc, wd, ba, us);
    checks++; if (bus.cpu_inst !== 32'h1111_0000 || wd !== 4 || ba !== 0) $display("FAIL post_reset_fill: inst %h words %0d bad %0d want 11110000 4 0", bus.cpu_inst, wd, ba); else passes++;
  endtask
  initial begin
    test_reset;
    test_cold_miss;
    test_line_hit;
    test_conflict;
    test_slow_mem;
    test_invalidate_refill;
    test_invalidate_idle;
    test_reset_mid_refill;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", passes, checks);
    $fatal(1);
  end
endmodule
